// File: rtl/atp_pkg.sv
// Shared definitions for the kiosk payment ledger scheduler.
// Holds the default widths, the FSM state encoding and the accepted
// rupee denominations. It has no ports.
package atp_pkg;

    localparam int unsigned NUM_KIOSK_DEF = 4;
    localparam int unsigned AMT_W_DEF     = 16;
    localparam int unsigned ACCT_W_DEF    = 8;
    localparam int unsigned TIMEOUT_DEF   = 255;

    // Scheduler FSM state encoding
    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] atp_state_t;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_ARB   = 3'd1;
    localparam logic [ST_W-1:0] ST_READ  = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [ST_W-1:0] ST_CALC  = 3'd4;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd5;
    localparam logic [ST_W-1:0] ST_RESP  = 3'd6;
    localparam logic [ST_W-1:0] ST_ERR   = 3'd7;

    // Coin and note values (rupees) the kiosks accept
    localparam int unsigned DENOM_CNT = 10;
    localparam int unsigned DENOMS [DENOM_CNT] = '{1, 2, 5, 10, 20, 50, 100, 200, 500, 2000};

endpackage

// File: rtl/atp_ledger_sched_if.sv
// Kiosk and ledger bus of the payment ledger scheduler.
// Kiosk side:  req, k_acct, k_amt in; gnt, done, err, bal_out, exc_out out.
// Ledger side: led_addr, led_rd_en, led_wr_en, led_wr_data out;
//              led_rd_valid, led_rd_data in.
// Status:      busy out.
// master = kiosks + ledger environment, slave = scheduler.
interface atp_ledger_sched_if
    import atp_pkg::*;
#(
    parameter int unsigned NUM_KIOSK = NUM_KIOSK_DEF,
    parameter int unsigned AMT_W     = AMT_W_DEF,
    parameter int unsigned ACCT_W    = ACCT_W_DEF
);

    logic [NUM_KIOSK-1:0]        req;
    logic [NUM_KIOSK*ACCT_W-1:0] k_acct;
    logic [NUM_KIOSK*AMT_W-1:0]  k_amt;
    logic [NUM_KIOSK-1:0]        gnt;
    logic [NUM_KIOSK-1:0]        done;
    logic                        err;
    logic [AMT_W-1:0]            bal_out;
    logic [AMT_W-1:0]            exc_out;
    logic [ACCT_W-1:0]           led_addr;
    logic                        led_rd_en;
    logic                        led_rd_valid;
    logic [AMT_W-1:0]            led_rd_data;
    logic                        led_wr_en;
    logic [AMT_W-1:0]            led_wr_data;
    logic                        busy;

    modport master (
        output req, k_acct, k_amt, led_rd_valid, led_rd_data,
        input  gnt, done, err, bal_out, exc_out,
        input  led_addr, led_rd_en, led_wr_en, led_wr_data, busy
    );

    modport slave (
        input  req, k_acct, k_amt, led_rd_valid, led_rd_data,
        output gnt, done, err, bal_out, exc_out,
        output led_addr, led_rd_en, led_wr_en, led_wr_data, busy
    );

endinterface

// File: rtl/atp_rr_arb.sv
// Round-robin kiosk selector: picks the first requesting kiosk at or after
// rr_ptr_i, wrapping from NUM_KIOSK-1 back to 0. Purely combinational.
// Ports: req_i (request vector), rr_ptr_i (search start),
//        winner_o (one-hot winner, zero when no request), winner_idx_o.
module atp_rr_arb #(
    parameter int unsigned NUM_KIOSK = 4,
    localparam int unsigned IDX_W = (NUM_KIOSK > 1) ? $clog2(NUM_KIOSK) : 1
) (
    input  logic [NUM_KIOSK-1:0] req_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic [NUM_KIOSK-1:0] winner_o,
    output logic [IDX_W-1:0]     winner_idx_o
);

    logic [31:0]      sum;
    logic [IDX_W-1:0] pos;
    logic             found;

    // Scan kiosks in rotated order; the first hit wins
    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        sum          = '0;
        pos          = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < NUM_KIOSK; i++) begin
            sum = 32'(rr_ptr_i) + i;
            if (sum >= NUM_KIOSK) begin
                sum = sum - NUM_KIOSK;
            end
            pos = IDX_W'(sum);
            if (!found && req_i[pos]) begin
                found         = 1'b1;
                winner_o[pos] = 1'b1;
                winner_idx_o  = pos;
            end
        end
    end

endmodule

// File: rtl/atp_ledger_sched.sv
// Kiosk payment ledger scheduler. Kiosks post payments against consumer
// accounts; one kiosk at a time is granted, its account's outstanding due
// is read from the ledger, reduced by the paid amount (excess reported
// separately) and written back, then the kiosk receives a done pulse.
// A ledger that does not answer within TIMEOUT cycles yields done with err.
// Ports: clk, rst (async, active-high), bus (slave side of the kiosk and
//        ledger interface). All bus outputs are registered.
module atp_ledger_sched
    import atp_pkg::*;
#(
    parameter int unsigned NUM_KIOSK = NUM_KIOSK_DEF,
    parameter int unsigned AMT_W     = AMT_W_DEF,
    parameter int unsigned ACCT_W    = ACCT_W_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    atp_ledger_sched_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_KIOSK > 1) ? $clog2(NUM_KIOSK) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    atp_state_t            state_q,   state_d;
    logic [IDX_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [AMT_W-1:0]      amt_q,     amt_d;
    logic [AMT_W-1:0]      due_q,     due_d;
    logic [AMT_W-1:0]      excess_q,  excess_d;
    logic [NUM_KIOSK-1:0]  gnt_q,     gnt_d;
    logic [NUM_KIOSK-1:0]  done_q,    done_d;
    logic                  err_q,     err_d;
    logic [AMT_W-1:0]      bal_q,     bal_d;
    logic [AMT_W-1:0]      exc_q,     exc_d;
    logic [ACCT_W-1:0]     addr_q,    addr_d;
    logic                  rd_en_q,   rd_en_d;
    logic                  wr_en_q,   wr_en_d;
    logic [AMT_W-1:0]      wr_data_q, wr_data_d;
    logic                  busy_q,    busy_d;

    logic [NUM_KIOSK-1:0]  arb_win;
    logic [IDX_W-1:0]      arb_idx;
    logic [ACCT_W-1:0]     win_acct;
    logic [AMT_W-1:0]      win_amt;

    atp_rr_arb #(
        .NUM_KIOSK (NUM_KIOSK)
    ) u_arb (
        .req_i        (bus.req),
        .rr_ptr_i     (rr_ptr_q),
        .winner_o     (arb_win),
        .winner_idx_o (arb_idx)
    );

    // One-hot mux of the winning kiosk's account and amount
    always_comb begin
        win_acct = '0;
        win_amt  = '0;
        for (int unsigned k = 0; k < NUM_KIOSK; k++) begin
            if (arb_win[k]) begin
                win_acct = win_acct | bus.k_acct[k*ACCT_W +: ACCT_W];
                win_amt  = win_amt  | bus.k_amt[k*AMT_W +: AMT_W];
            end
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        amt_d     = amt_q;
        due_d     = due_q;
        excess_d  = excess_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        bal_d     = bal_q;
        exc_d     = exc_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // A request withdrawn before arbitration is simply dropped
                if (|bus.req) begin
                    gnt_d    = arb_win;
                    addr_d   = win_acct;
                    amt_d    = win_amt;
                    rr_ptr_d = (arb_idx == IDX_W'(NUM_KIOSK - 1)) ? '0 : arb_idx + IDX_W'(1);
                    rd_en_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data arriving on the last allowed cycle still counts
                if (bus.led_rd_valid) begin
                    due_d   = bus.led_rd_data;
                    state_d = ST_CALC;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    bal_d   = '0;
                    exc_d   = '0;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CALC: begin
                // Saturate the due at zero and report any overpayment
                if (amt_q <= due_q) begin
                    wr_data_d = due_q - amt_q;
                    excess_d  = '0;
                end else begin
                    wr_data_d = '0;
                    excess_d  = amt_q - due_q;
                end
                wr_en_d = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                done_d  = gnt_q;
                bal_d   = wr_data_q;
                exc_d   = excess_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            amt_q     <= '0;
            due_q     <= '0;
            excess_q  <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            bal_q     <= '0;
            exc_q     <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            amt_q     <= amt_d;
            due_q     <= due_d;
            excess_q  <= excess_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bal_q     <= bal_d;
            exc_q     <= exc_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.bal_out     = bal_q;
    assign bus.exc_out     = exc_q;
    assign bus.led_addr    = addr_q;
    assign bus.led_rd_en   = rd_en_q;
    assign bus.led_wr_en   = wr_en_q;
    assign bus.led_wr_data = wr_data_q;
    assign bus.busy        = busy_q;

endmodule
